// File: rtl/braille_display_ctrl.sv
// rtl/braille_display_ctrl.sv - multi-digit Braille letter display on active-low 7-segment digits
// Optional feature macro: BRAILLE_CURSOR_BLINK_EN (blinks segment g on the LEDR-marked digit)
module braille_display_ctrl #(
    parameter int NUM_DIGITS      = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int BLINK_DIV       = 25000000
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic [4:0]              SW,
    input  logic                    MODE,
    input  logic [NUM_DIGITS-1:0]   KEY,
    output logic [7*NUM_DIGITS-1:0] HEX,
    output logic [NUM_DIGITS-1:0]   LEDR,
    output logic                    invalid
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [NUM_DIGITS-1:0]   r_sync1;
    logic [NUM_DIGITS-1:0]   r_sync2;
    logic [NUM_DIGITS-1:0]   r_stable;
    logic [NUM_DIGITS-1:0]   r_press;
    logic [CW-1:0]           r_cnt [NUM_DIGITS];
    logic [4:0]              r_code [NUM_DIGITS];
    logic [7*NUM_DIGITS-1:0] r_hex;
    logic [NUM_DIGITS-1:0]   r_ledr;
    logic                    r_invalid;
    logic [NUM_DIGITS-1:0]   w_top_onehot;
    logic                    w_blink_phase;

    // Braille dot set for a letter code; bit n-1 is dot n, blank for codes outside 1..26
    function automatic logic [5:0] braille_dots(input logic [4:0] code);
        logic [5:0] d;
        d = 6'h00;
        case (code)
            5'd1:  d = 6'h01;  5'd2:  d = 6'h03;  5'd3:  d = 6'h09;  5'd4:  d = 6'h19;
            5'd5:  d = 6'h11;  5'd6:  d = 6'h0B;  5'd7:  d = 6'h1B;  5'd8:  d = 6'h13;
            5'd9:  d = 6'h0A;  5'd10: d = 6'h1A;  5'd11: d = 6'h05;  5'd12: d = 6'h07;
            5'd13: d = 6'h0D;  5'd14: d = 6'h1D;  5'd15: d = 6'h15;  5'd16: d = 6'h0F;
            5'd17: d = 6'h1F;  5'd18: d = 6'h17;  5'd19: d = 6'h0E;  5'd20: d = 6'h1E;
            5'd21: d = 6'h25;  5'd22: d = 6'h27;  5'd23: d = 6'h3A;  5'd24: d = 6'h2D;
            5'd25: d = 6'h3D;  5'd26: d = 6'h35;
            default: d = 6'h00;
        endcase
        return d;
    endfunction

    // Active-low segments: dot1->a, dot4->b, dot5->c, dot6->d, dot3->e, dot2->f, g only for the cursor
    function automatic logic [6:0] dots_to_seg(input logic [5:0] d, input logic g_lit);
        return {~g_lit, ~d[1], ~d[2], ~d[5], ~d[4], ~d[3], ~d[0]};
    endfunction

    // Synchronise, debounce and detect the stable 1->0 transition of every key
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_stable <= '1;
            r_press  <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= KEY;
            r_sync2 <= r_sync1;
            r_press <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (r_sync2[i] != r_stable[i]) begin
                    if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        r_stable[i] <= r_sync2[i];
                        r_cnt[i]    <= '0;
                        r_press[i]  <= ~r_sync2[i];
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CW'(1);
                    end
                end else begin
                    r_cnt[i] <= '0;
                end
            end
        end
    end

    // One-hot of the highest-indexed key pressed this cycle
    always_comb begin
        w_top_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_press[i]) w_top_onehot = NUM_DIGITS'(1) << i;
        end
    end

    // Latch SW into the digit registers on a press: direct write or a single left shift
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) r_code[i] <= '0;
            r_ledr    <= '0;
            r_invalid <= 1'b0;
        end else if (|r_press) begin
            if (MODE) begin
                for (int k = NUM_DIGITS - 1; k > 0; k--) r_code[k] <= r_code[k-1];
                r_code[0] <= SW;
                r_ledr    <= NUM_DIGITS'(1);
            end else begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (r_press[i]) r_code[i] <= SW;
                end
                r_ledr <= w_top_onehot;
            end
            r_invalid <= (SW == 5'd0) || (SW > 5'd26);
        end
    end

`ifdef BRAILLE_CURSOR_BLINK_EN
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;

    // Free-running divider toggling the cursor phase every BLINK_DIV clocks
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (r_blink_cnt == BW'(BLINK_DIV - 1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
        end
    end

    assign w_blink_phase = r_blink_phase;
`else
    assign w_blink_phase = 1'b0 & (BLINK_DIV > 0);
`endif

    // Registered decode of every digit to its segment pattern
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_hex <= '1;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_hex[7*i +: 7] <= dots_to_seg(braille_dots(r_code[i]), r_ledr[i] & w_blink_phase);
            end
        end
    end

    assign HEX     = r_hex;
    assign LEDR    = r_ledr;
    assign invalid = r_invalid;

endmodule

// File: tb/tb_braille_display_ctrl.sv
// tb/tb_braille_display_ctrl.sv - self-checking bench for braille_display_ctrl
module tb_braille_display_ctrl;

    localparam int N = 4;
    localparam int D = 16;

`ifdef BRAILLE_CURSOR_BLINK_EN
    localparam logic [7*N-1:0] HM = {N{7'h3F}};
`else
    localparam logic [7*N-1:0] HM = '1;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [4:0]     SW = '0;
    logic           MODE = 1'b0;
    logic [N-1:0]   KEY = '1;
    logic [7*N-1:0] HEX;
    logic [N-1:0]   LEDR;
    logic           invalid;

    int n_cmp = 0;
    int n_bad = 0;

    int           m_code [N];
    logic [N-1:0] m_ledr;
    logic         m_inv;

    string braille [26] = '{"1", "12", "14", "145", "15", "124", "1245", "125", "24", "245",
                            "13", "123", "134", "1345", "135", "1234", "12345", "1235", "234", "2345",
                            "136", "1236", "2456", "1346", "13456", "1356"};
    int dot_seg [7] = '{0, 0, 5, 4, 1, 2, 3};

    braille_display_ctrl #(.NUM_DIGITS(N), .DEBOUNCE_CYCLES(D), .BLINK_DIV(8)) dut (
        .CLOCK_50(clk), .reset(reset), .SW(SW), .MODE(MODE), .KEY(KEY),
        .HEX(HEX), .LEDR(LEDR), .invalid(invalid)
    );

    always #5 clk = ~clk;

    function automatic logic [7*N-1:0] exp_hex();
        logic [7*N-1:0] h;
        logic [6:0] v;
        string s;
        h = '1;
        for (int d = 0; d < N; d++) begin
            v = 7'h7F;
            if (m_code[d] >= 1 && m_code[d] <= 26) begin
                s = braille[m_code[d] - 1];
                for (int j = 0; j < s.len(); j++) v[dot_seg[s[j] - 8'd48]] = 1'b0;
            end
            h[7*d +: 7] = v;
        end
        return h;
    endfunction

    function automatic logic [6:0] mk(input logic [6:0] v);
        return v & HM[6:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_code[i] = 0;
        m_ledr = '0;
        m_inv  = 1'b0;
    endtask

    task automatic model_press(input logic [N-1:0] mask, input logic mode, input int sw);
        if (mode) begin
            for (int k = N - 1; k > 0; k--) m_code[k] = m_code[k-1];
            m_code[0] = sw;
            m_ledr = 1;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    m_code[i] = sw;
                    m_ledr = '0;
                    m_ledr[i] = 1'b1;
                end
            end
        end
        m_inv = (sw == 0) || (sw > 26);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        KEY = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic do_press(input logic [N-1:0] mask, input logic mode, input int sw, input int hold);
        @(negedge clk);
        MODE = mode;
        SW = 5'(sw);
        KEY = ~mask;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        KEY = '1;
        repeat (D + 8) @(posedge clk);
        @(negedge clk);
        model_press(mask, mode, sw);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (HEX !== 28'hFFFFFFF) begin n_bad++; $display("FAIL reset_hex actual=%h expected=%h", HEX, 28'hFFFFFFF); end
        n_cmp++; if (LEDR !== 4'b0000) begin n_bad++; $display("FAIL reset_ledr actual=%b expected=0000", LEDR); end
        n_cmp++; if (invalid !== 1'b0) begin n_bad++; $display("FAIL reset_invalid actual=%b expected=0", invalid); end
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        SW = 5'd3;
        KEY[2] = 1'b0;
        repeat (D / 2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        KEY = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (2 * D + 8) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ((HEX & HM) !== (28'hFFFFFFF & HM)) begin n_bad++; $display("FAIL reset_abort_hex actual=%h expected=%h", HEX, 28'hFFFFFFF); end
        n_cmp++; if (LEDR !== 4'b0000) begin n_bad++; $display("FAIL reset_abort_ledr actual=%b expected=0000", LEDR); end
    endtask

    task automatic test_direct();
        @(negedge clk);
        MODE = 1'b0;
        SW = 5'd1;
        KEY[0] = 1'b0;
        repeat (D + 3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ((HEX & HM) !== (28'hFFFFFFF & HM)) begin n_bad++; $display("FAIL direct_early actual=%h expected=%h", HEX, 28'hFFFFFFF); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (mk(HEX[6:0]) !== mk(7'h7E)) begin n_bad++; $display("FAIL direct_digit0 actual=%h expected=7e", HEX[6:0]); end
        n_cmp++; if ((HEX[27:7] & HM[27:7]) !== ({3{7'h7F}} & HM[27:7])) begin n_bad++; $display("FAIL direct_others actual=%h expected=%h", HEX[27:7], {3{7'h7F}}); end
        n_cmp++; if (LEDR !== 4'b0001) begin n_bad++; $display("FAIL direct_ledr actual=%b expected=0001", LEDR); end
        repeat (40 - D - 4) @(posedge clk);
        @(negedge clk);
        KEY = '1;
        repeat (D + 8) @(posedge clk);
        @(negedge clk);
        model_press(4'b0001, 1'b0, 1);
        n_cmp++; if ((HEX & HM) !== (exp_hex() & HM)) begin n_bad++; $display("FAIL direct_model actual=%h expected=%h", HEX, exp_hex()); end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        MODE = 1'b0;
        SW = 5'd9;
        KEY[1] = 1'b0;
        repeat (D - 1) @(posedge clk);
        @(negedge clk);
        KEY = '1;
        repeat (D + 8) @(posedge clk);
        @(negedge clk);
        n_cmp++; if ((HEX & HM) !== (exp_hex() & HM)) begin n_bad++; $display("FAIL glitch_nowrite actual=%h expected=%h", HEX, exp_hex()); end
        do_press(4'b0010, 1'b0, 26, D + 6);
        n_cmp++; if (mk(HEX[13:7]) !== mk(7'h62)) begin n_bad++; $display("FAIL glitch_z actual=%h expected=62", HEX[13:7]); end
        n_cmp++; if ((HEX & HM) !== (exp_hex() & HM)) begin n_bad++; $display("FAIL glitch_model actual=%h expected=%h", HEX, exp_hex()); end
        n_cmp++; if (LEDR !== 4'b0010) begin n_bad++; $display("FAIL glitch_ledr actual=%b expected=0010", LEDR); end
    endtask

    task automatic test_shift();
        do_reset();
        do_press(4'b0100, 1'b1, 1, D + 5);
        do_press(4'b0001, 1'b1, 2, D + 5);
        do_press(4'b1010, 1'b1, 23, D + 5);
        n_cmp++; if (mk(HEX[6:0]) !== mk(7'h51)) begin n_bad++; $display("FAIL shift_d0 actual=%h expected=51", HEX[6:0]); end
        n_cmp++; if (mk(HEX[13:7]) !== mk(7'h5E)) begin n_bad++; $display("FAIL shift_d1 actual=%h expected=5e", HEX[13:7]); end
        n_cmp++; if (mk(HEX[20:14]) !== mk(7'h7E)) begin n_bad++; $display("FAIL shift_d2 actual=%h expected=7e", HEX[20:14]); end
        n_cmp++; if (mk(HEX[27:21]) !== mk(7'h7F)) begin n_bad++; $display("FAIL shift_d3 actual=%h expected=7f", HEX[27:21]); end
        n_cmp++; if (LEDR !== 4'b0001) begin n_bad++; $display("FAIL shift_ledr actual=%b expected=0001", LEDR); end
    endtask

    task automatic test_simultaneous();
        do_press(4'b1001, 1'b0, 27, D + 6);
        n_cmp++; if (mk(HEX[6:0]) !== mk(7'h7F)) begin n_bad++; $display("FAIL simul_d0 actual=%h expected=7f", HEX[6:0]); end
        n_cmp++; if (mk(HEX[27:21]) !== mk(7'h7F)) begin n_bad++; $display("FAIL simul_d3 actual=%h expected=7f", HEX[27:21]); end
        n_cmp++; if (invalid !== 1'b1) begin n_bad++; $display("FAIL simul_invalid actual=%b expected=1", invalid); end
        n_cmp++; if (LEDR !== 4'b1000) begin n_bad++; $display("FAIL simul_ledr actual=%b expected=1000", LEDR); end
        do_press(4'b0010, 1'b0, 5, D + 6);
        n_cmp++; if (invalid !== 1'b0) begin n_bad++; $display("FAIL simul_valid actual=%b expected=0", invalid); end
        n_cmp++; if ((HEX & HM) !== (exp_hex() & HM)) begin n_bad++; $display("FAIL simul_model actual=%h expected=%h", HEX, exp_hex()); end
    endtask

    task automatic test_hold();
        do_press(4'b0100, 1'b1, $urandom_range(1, 26), 6 * D);
        n_cmp++; if ((HEX & HM) !== (exp_hex() & HM)) begin n_bad++; $display("FAIL hold_norepeat actual=%h expected=%h", HEX, exp_hex()); end
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        logic         mode;
        int           sw;
        for (int it = 0; it < 14; it++) begin
            mask = N'($urandom_range(1, 15));
            mode = 1'($urandom_range(0, 1));
            sw   = $urandom_range(0, 31);
            do_press(mask, mode, sw, $urandom_range(D + 4, 3 * D));
            n_cmp++; if ((HEX & HM) !== (exp_hex() & HM)) begin n_bad++; $display("FAIL random_hex it=%0d actual=%h expected=%h", it, HEX, exp_hex()); end
            n_cmp++; if (LEDR !== m_ledr) begin n_bad++; $display("FAIL random_ledr it=%0d actual=%b expected=%b", it, LEDR, m_ledr); end
            n_cmp++; if (invalid !== m_inv) begin n_bad++; $display("FAIL random_invalid it=%0d actual=%b expected=%b", it, invalid, m_inv); end
        end
    endtask

`ifdef BRAILLE_CURSOR_BLINK_EN
    task automatic test_blink();
        logic g [48];
        int   idx;
        int   last;
        int   nchg;
        int   bad_other;
        int   bad_gap;
        idx = 0;
        for (int i = 0; i < N; i++) if (m_ledr[i]) idx = i;
        bad_other = 0;
        for (int t = 0; t < 48; t++) begin
            @(negedge clk);
            g[t] = HEX[7*idx + 6];
            for (int i = 0; i < N; i++) if (i != idx && HEX[7*i + 6] !== 1'b1) bad_other++;
        end
        last = -1;
        nchg = 0;
        bad_gap = 0;
        for (int t = 1; t < 48; t++) begin
            if (g[t] !== g[t-1]) begin
                if (last >= 0 && (t - last) != 8) bad_gap++;
                last = t;
                nchg++;
            end
        end
        n_cmp++; if (nchg < 4) begin n_bad++; $display("FAIL blink_toggles actual=%0d expected>=4", nchg); end
        n_cmp++; if (bad_gap != 0) begin n_bad++; $display("FAIL blink_period actual_bad_gaps=%0d expected=0", bad_gap); end
        n_cmp++; if (bad_other != 0) begin n_bad++; $display("FAIL blink_others actual_lit=%0d expected=0", bad_other); end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_direct();
        test_glitch();
        test_shift();
        test_simultaneous();
        test_hold();
        test_random();
`ifdef BRAILLE_CURSOR_BLINK_EN
        test_blink();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
